// File: rtl/half_sub.sv
// Single-bit half subtractor: diff = x - y, bor set when x < y.
module half_sub (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic bor
);

    assign diff = x ^ y;
    assign bor  = ~x & y;

endmodule

// File: rtl/fs_by_hs.sv
// Registered ripple-borrow subtractor: {ba, d} = a - b - c, one cycle latency.
// Each bit is a full subtractor made of two half subtractors plus an OR.
module fs_by_hs #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             ba
);

    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] diff;
    // bin[i] is the borrow into bit i; bin[WIDTH] is the final borrow-out.
    logic [WIDTH:0]   bin;

    assign bin[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        half_sub u_hs1 (
            .x    (a[i]),
            .y    (b[i]),
            .diff (d1[i]),
            .bor  (b1[i])
        );

        half_sub u_hs2 (
            .x    (d1[i]),
            .y    (bin[i]),
            .diff (diff[i]),
            .bor  (b2[i])
        );

        assign bin[i+1] = b1[i] | b2[i];
    end

    // Capture result on valid input; otherwise hold d/ba and drop out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            ba        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d  <= diff;
                ba <= bin[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fs_by_hs.sv
// Directed and random checks of fs_by_hs at WIDTH=1 and WIDTH=8.
module tb_fs_by_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       v1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       c1 = 1'b0;
    logic       ov1;
    logic       d1;
    logic       ba1;

    logic       v8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       ov8;
    logic [7:0] d8;
    logic       ba8;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    fs_by_hs #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .out_valid (ov1),
        .d         (d1),
        .ba        (ba1)
    );

    fs_by_hs #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .c         (c8),
        .out_valid (ov8),
        .d         (d8),
        .ba        (ba8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference {ov, ba, d} for an 8-bit valid vector.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        r = {1'b0, a} - {1'b0, b} - {8'd0, c};
        return {1'b1, r};
    endfunction

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        v8 = v;
        a8 = a;
        b8 = b;
        c8 = c;
    endtask

    initial begin
        logic [1:0] exp1 [8];
        logic [9:0] exp8;
        logic [9:0] held;
        logic [2:0] abc;

        // Hand-computed {ba, d} for WIDTH=1, indexed by {a, b, c}.
        exp1[0] = 2'b00; exp1[1] = 2'b11; exp1[2] = 2'b11; exp1[3] = 2'b10;
        exp1[4] = 2'b01; exp1[5] = 2'b00; exp1[6] = 2'b00; exp1[7] = 2'b11;

        // Reset state before any clock edge.
        #1;
        check("rst_w1", {29'd0, ov1, ba1, d1}, 32'd0);
        check("rst_w8", {22'd0, ov8, ba8, d8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=1 exhaustive.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            v1 = 1'b1;
            {a1, b1, c1} = abc;
            @(negedge clk);
            check($sformatf("w1_abc%0d", i), {29'd0, ov1, ba1, d1}, {29'd0, 1'b1, exp1[i]});
        end
        v1 = 1'b0;

        // WIDTH=8 boundaries, hand-computed.
        drive8(1'b1, 8'h00, 8'h01, 1'b0);
        @(negedge clk);
        check("w8_0m1", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b1, 8'hFF});
        drive8(1'b1, 8'h80, 8'h7F, 1'b1);
        @(negedge clk);
        check("w8_80m7f1", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b0, 8'h00});
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        check("w8_ffmff1", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b1, 8'hFF});
        drive8(1'b1, 8'h00, 8'hFF, 1'b1);
        @(negedge clk);
        check("w8_0mff1", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b1, 8'h00});
        drive8(1'b1, 8'h5A, 8'h5A, 1'b0);
        @(negedge clk);
        check("w8_eq0", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b0, 8'h00});

        // Hold: one valid result, then three idle cycles with changing operands.
        drive8(1'b1, 8'h10, 8'h03, 1'b1);
        @(negedge clk);
        check("hold_load", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b0, 8'h0C});
        held = {1'b0, 1'b0, 8'h0C};
        for (int i = 0; i < 3; i++) begin
            drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            check($sformatf("hold_%0d", i), {22'd0, ov8, ba8, d8}, {22'd0, held});
        end

        // Back-to-back: four consecutive valid vectors.
        drive8(1'b1, 8'h01, 8'h02, 1'b0);
        @(negedge clk);
        check("b2b_0", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b1, 8'hFF});
        drive8(1'b1, 8'h64, 8'h32, 1'b1);
        @(negedge clk);
        check("b2b_1", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b0, 8'h31});
        drive8(1'b1, 8'h7F, 8'h80, 1'b0);
        @(negedge clk);
        check("b2b_2", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b1, 8'hFF});
        drive8(1'b1, 8'hC8, 8'h37, 1'b0);
        @(negedge clk);
        check("b2b_3", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b0, 8'h91});

        // Async reset between edges with nonzero outputs.
        drive8(1'b1, 8'h00, 8'h01, 1'b0);
        v1 = 1'b1;
        {a1, b1, c1} = 3'b001;
        @(negedge clk);
        check("pre_rst", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b1, 8'hFF});
        #2;
        rst = 1'b1;
        #1;
        check("async_w8", {22'd0, ov8, ba8, d8}, 32'd0);
        check("async_w1", {29'd0, ov1, ba1, d1}, 32'd0);
        @(negedge clk);
        check("rst_held", {22'd0, ov8, ba8, d8}, 32'd0);
        rst = 1'b0;
        v1 = 1'b0;
        drive8(1'b0, 8'h00, 8'h01, 1'b0);
        @(negedge clk);
        check("post_rst_idle", {22'd0, ov8, ba8, d8}, 32'd0);
        drive8(1'b1, 8'h09, 8'h04, 1'b0);
        @(negedge clk);
        check("post_rst_cap", {22'd0, ov8, ba8, d8}, {22'd0, 1'b1, 1'b0, 8'h05});

        // Random back-to-back vectors against the reference model.
        for (int i = 0; i < 10000; i++) begin
            drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            exp8 = ref8(a8, b8, c8);
            @(negedge clk);
            check("rand", {22'd0, ov8, ba8, d8}, {22'd0, exp8});
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
